// File: rtl/chan_cmul_sym_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | chan_cmul_sym_if : streaming I/Q bus for the channel-gain multiplier     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface chan_cmul_sym_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] DAT_I;
  logic            CYC_I;
  logic            STB_I;
  logic            WE_I;
  logic            ACK_O;
  logic [2*DW-1:0] DAT_O;
  logic            STB_O;
  logic            CYC_O;
  logic            WE_O;
  logic            ACK_I;

  // slave = the multiplier; master = the surrounding upstream/downstream pair
  modport slave  (input  DAT_I, CYC_I, STB_I, WE_I, ACK_I,
                  output ACK_O, DAT_O, STB_O, CYC_O, WE_O);
  modport master (output DAT_I, CYC_I, STB_I, WE_I, ACK_I,
                  input  ACK_O, DAT_O, STB_O, CYC_O, WE_O);
endinterface
`default_nettype wire

// File: rtl/chan_cmul_sym.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | chan_cmul_sym : 3-stage stallable complex gain multiplier, gain latched  |
// | per symbol. Optional macro CHAN_CMUL_SAT_EN: saturate + SAT_FLAG_O.      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module chan_cmul_sym #(
  parameter int DW      = 16,
  parameter int FRAC    = 15,
  parameter int SYM_LEN = 480,
  parameter int CW      = 9
) (
  input  wire logic          CLK_I,
  input  wire logic          RST_I,
  chan_cmul_sym_if.slave     bus,
  input  wire logic [DW-1:0] GAIN_RE_I,
  input  wire logic [DW-1:0] GAIN_IM_I,
  input  wire logic [1:0]    MODE_I,
  output logic      [CW-1:0] SYM_CNT_O,
  output logic               SYM_END_O
`ifdef CHAN_CMUL_SAT_EN
  ,
  output logic               SAT_FLAG_O
`endif
);

  localparam logic [CW-1:0]        c_last = CW'(SYM_LEN - 1);
  localparam logic [CW-1:0]        c_one  = CW'(1);
  localparam logic signed [2*DW:0] c_half = (2*DW+1)'(1) << (FRAC - 1);

  logic                 w_halt;
  logic                 w_accept;
  logic                 w_cyc_rise;
  logic [CW-1:0]        w_idx;
  logic                 w_idx0;
  logic signed [DW-1:0] w_gre;
  logic signed [DW-1:0] w_gim;
  logic                 w_byp;

  logic                 r_cyc_d;
  logic [CW-1:0]        r_cnt;
  logic                 r_sym_end;
  logic signed [DW-1:0] r_gain_re;
  logic signed [DW-1:0] r_gain_im;
  logic                 r_byp;

  logic                 r_s1_v;
  logic                 r_s1_byp;
  logic [2*DW-1:0]      r_s1_dat;
  logic signed [DW-1:0] r_s1_gre;
  logic signed [DW-1:0] r_s1_gim;

  logic                   r_s2_v;
  logic                   r_s2_byp;
  logic [2*DW-1:0]        r_s2_dat;
  logic signed [2*DW-1:0] r_s2_prr;
  logic signed [2*DW-1:0] r_s2_pii;
  logic signed [2*DW-1:0] r_s2_pri;
  logic signed [2*DW-1:0] r_s2_pir;

  logic [2*DW-1:0] r_dat_o;
  logic            r_stb_o;
  logic            r_cyc_o;

  logic signed [DW-1:0]  w_a_re;
  logic signed [DW-1:0]  w_a_im;
  logic signed [2*DW:0]  w_re_sum;
  logic signed [2*DW:0]  w_im_sum;
  logic signed [2*DW:0]  w_re_sh;
  logic signed [2*DW:0]  w_im_sh;
  logic [DW-1:0]         w_re_out;
  logic [DW-1:0]         w_im_out;

  assign w_halt     = r_stb_o & ~bus.ACK_I;
  assign w_accept   = bus.CYC_I & bus.STB_I & bus.WE_I & ~w_halt;
  assign w_cyc_rise = bus.CYC_I & ~r_cyc_d;
  assign w_idx      = w_cyc_rise ? '0 : r_cnt;
  assign w_idx0     = (w_idx == '0);

  // The index-0 sample must already use the gain it latches
  always_comb begin
    w_gre = r_gain_re;
    w_gim = r_gain_im;
    w_byp = r_byp;
    if (w_idx0) begin
      w_gre = GAIN_RE_I;
      w_gim = (MODE_I == 2'b01) ? '0 : GAIN_IM_I;
      w_byp = (MODE_I == 2'b00);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cyc_d   <= 1'b0;
      r_cnt     <= '0;
      r_sym_end <= 1'b0;
      r_gain_re <= '0;
      r_gain_im <= '0;
      r_byp     <= 1'b1;
    end else begin
      r_cyc_d   <= bus.CYC_I;
      r_sym_end <= 1'b0;
      if (w_accept) begin
        r_cnt     <= (w_idx == c_last) ? '0 : w_idx + c_one;
        r_sym_end <= (w_idx == c_last);
        if (w_idx0) begin
          r_gain_re <= w_gre;
          r_gain_im <= w_gim;
          r_byp     <= w_byp;
        end
      end else if (w_cyc_rise) begin
        r_cnt <= '0;
      end
    end
  end

  assign w_a_re = r_s1_dat[DW-1:0];
  assign w_a_im = r_s1_dat[2*DW-1:DW];

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_s1_v   <= 1'b0;
      r_s1_byp <= 1'b1;
      r_s1_dat <= '0;
      r_s1_gre <= '0;
      r_s1_gim <= '0;
      r_s2_v   <= 1'b0;
      r_s2_byp <= 1'b1;
      r_s2_dat <= '0;
      r_s2_prr <= '0;
      r_s2_pii <= '0;
      r_s2_pri <= '0;
      r_s2_pir <= '0;
      r_dat_o  <= '0;
      r_stb_o  <= 1'b0;
    end else if (!w_halt) begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_byp <= w_byp;
        r_s1_dat <= bus.DAT_I;
        r_s1_gre <= w_gre;
        r_s1_gim <= w_gim;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_byp <= r_s1_byp;
        r_s2_dat <= r_s1_dat;
        r_s2_prr <= (2*DW)'(w_a_re) * (2*DW)'(r_s1_gre);
        r_s2_pii <= (2*DW)'(w_a_im) * (2*DW)'(r_s1_gim);
        r_s2_pri <= (2*DW)'(w_a_re) * (2*DW)'(r_s1_gim);
        r_s2_pir <= (2*DW)'(w_a_im) * (2*DW)'(r_s1_gre);
      end
      // Not halted means any held output has just been taken
      r_stb_o <= r_s2_v;
      if (r_s2_v) begin
        r_dat_o <= r_s2_byp ? r_s2_dat : {w_im_out, w_re_out};
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cyc_o <= 1'b0;
    end else if (w_accept) begin
      r_cyc_o <= 1'b1;
    end else if (!bus.CYC_I && !r_s1_v && !r_s2_v && !r_stb_o) begin
      r_cyc_o <= 1'b0;
    end
  end

  assign w_re_sum = {r_s2_prr[2*DW-1], r_s2_prr} - {r_s2_pii[2*DW-1], r_s2_pii} + c_half;
  assign w_im_sum = {r_s2_pri[2*DW-1], r_s2_pri} + {r_s2_pir[2*DW-1], r_s2_pir} + c_half;
  assign w_re_sh  = w_re_sum >>> FRAC;
  assign w_im_sh  = w_im_sum >>> FRAC;

`ifdef CHAN_CMUL_SAT_EN
  localparam logic signed [2*DW:0] c_max = (2*DW+1)'((1 << (DW - 1)) - 1);
  localparam logic signed [2*DW:0] c_min = ~c_max;

  logic w_re_hi;
  logic w_re_lo;
  logic w_im_hi;
  logic w_im_lo;
  logic r_sat_flag;

  assign w_re_hi  = (w_re_sh > c_max);
  assign w_re_lo  = (w_re_sh < c_min);
  assign w_im_hi  = (w_im_sh > c_max);
  assign w_im_lo  = (w_im_sh < c_min);
  assign w_re_out = w_re_hi ? c_max[DW-1:0] : (w_re_lo ? c_min[DW-1:0] : w_re_sh[DW-1:0]);
  assign w_im_out = w_im_hi ? c_max[DW-1:0] : (w_im_lo ? c_min[DW-1:0] : w_im_sh[DW-1:0]);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sat_flag <= 1'b0;
    end else if (!w_halt && r_s2_v && !r_s2_byp &&
                 (w_re_hi || w_re_lo || w_im_hi || w_im_lo)) begin
      r_sat_flag <= 1'b1;
    end else if (w_cyc_rise) begin
      r_sat_flag <= 1'b0;
    end
  end

  assign SAT_FLAG_O = r_sat_flag;
`else
  logic w_unused_hi;

  assign w_re_out    = w_re_sh[DW-1:0];
  assign w_im_out    = w_im_sh[DW-1:0];
  assign w_unused_hi = ^{w_re_sh[2*DW:DW], w_im_sh[2*DW:DW]};
`endif

  assign bus.ACK_O = w_accept;
  assign bus.DAT_O = r_dat_o;
  assign bus.STB_O = r_stb_o;
  assign bus.WE_O  = r_stb_o;
  assign bus.CYC_O = r_cyc_o;
  assign SYM_CNT_O = r_cnt;
  assign SYM_END_O = r_sym_end;

endmodule
`default_nettype wire

// File: tb/tb_chan_cmul_sym.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_chan_cmul_sym : randomized bench with arithmetic reference model       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_chan_cmul_sym;
  localparam int DW = 16, FRAC = 15, SYM_LEN = 4, CW = 2;

  logic CLK_I = 1'b0;
  logic RST_I;
  always #5 CLK_I = ~CLK_I;

  chan_cmul_sym_if #(.DW(DW)) bus ();
  logic [DW-1:0] gain_re, gain_im;
  logic [1:0]    mode;
  logic [CW-1:0] sym_cnt;
  logic          sym_end;
`ifdef CHAN_CMUL_SAT_EN
  logic          sat_flag;
`endif

  chan_cmul_sym #(.DW(DW), .FRAC(FRAC), .SYM_LEN(SYM_LEN), .CW(CW)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .bus       (bus),
    .GAIN_RE_I (gain_re),
    .GAIN_IM_I (gain_im),
    .MODE_I    (mode),
    .SYM_CNT_O (sym_cnt),
    .SYM_END_O (sym_end)
`ifdef CHAN_CMUL_SAT_EN
    ,
    .SAT_FLAG_O(sat_flag)
`endif
  );

  int checks = 0, errors = 0, stepno = 0;
  bit last_ack;

  // reference model state
  int              m_cnt;
  bit              m_prev_cyc;
  longint          m_gre, m_gim;
  bit              m_byp, m_sat;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] got_q[$];
  int              end_log[$];
  int              exp_end_q[$];

  function automatic logic [DW-1:0] reduce(longint v);
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(longint'(1) <<< (DW - 1));
    logic [63:0] vb = v;
`ifdef CHAN_CMUL_SAT_EN
    if (v > hi) begin m_sat = 1'b1; vb = hi; end
    if (v < lo) begin m_sat = 1'b1; vb = lo; end
`endif
    return vb[DW-1:0];
  endfunction

  function automatic logic [2*DW-1:0] ref_mul(logic [2*DW-1:0] a);
    longint ar, ai, re, im;
    if (m_byp) return a;
    ar = longint'($signed(a[DW-1:0]));
    ai = longint'($signed(a[2*DW-1:DW]));
    re = ((ar * m_gre - ai * m_gim) + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    im = ((ar * m_gim + ai * m_gre) + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    return {reduce(im), reduce(re)};
  endfunction

  task automatic reset_model();
    m_cnt = 0; m_prev_cyc = 0; m_gre = 0; m_gim = 0; m_byp = 1; m_sat = 0;
    exp_q.delete(); got_q.delete(); end_log.delete(); exp_end_q.delete();
  endtask

  // One clock: observe mid-cycle, advance the model, then cross the edge.
  task automatic step();
    bit rise;
    int idx;
    #1;
    last_ack = bus.ACK_O;
    if (bus.STB_O && bus.ACK_I) got_q.push_back(bus.DAT_O);
    if (sym_end) end_log.push_back(stepno);
    rise = bus.CYC_I && !m_prev_cyc;
    idx  = rise ? 0 : m_cnt;
    if (rise) m_sat = 0;
    if (last_ack) begin
      if (idx == 0) begin
        m_gre = longint'($signed(gain_re));
        m_gim = (mode == 2'b01) ? 0 : longint'($signed(gain_im));
        m_byp = (mode == 2'b00);
      end
      exp_q.push_back(ref_mul(bus.DAT_I));
      if (idx == SYM_LEN - 1) exp_end_q.push_back(stepno + 1);
      m_cnt = (idx == SYM_LEN - 1) ? 0 : idx + 1;
    end else if (rise) begin
      m_cnt = 0;
    end
    m_prev_cyc = bus.CYC_I;
    @(posedge CLK_I);
    @(negedge CLK_I);
    stepno++;
  endtask

  task automatic drain();
    bus.STB_I = 0; bus.CYC_I = 0; bus.ACK_I = 1;
    step();
    for (int i = 0; i < 20; i++) begin
      if (!bus.STB_O && !bus.CYC_O) break;
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.DAT_O !== '0) begin errors++; $display("FAIL reset_dat got=%h exp=0", bus.DAT_O); end
    checks++; if ({bus.STB_O, bus.WE_O, bus.CYC_O} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {bus.STB_O, bus.WE_O, bus.CYC_O}); end
    checks++; if ({sym_cnt, sym_end} !== '0) begin errors++; $display("FAIL reset_sym got=%h exp=0", {sym_cnt, sym_end}); end
    @(negedge CLK_I);
    RST_I = 0;
    reset_model();
    step();
    checks++; if (last_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got=%b exp=0", last_ack); end
  endtask

  task automatic test_real_latency();
    mode = 2'b01; gain_re = 16'h4000; gain_im = 16'($urandom_range(1, 16'hFFFF));
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1; bus.DAT_I = 32'h0000_2000;
    step();
    checks++; if (last_ack !== 1'b1) begin errors++; $display("FAIL lat_ack got=%b exp=1", last_ack); end
    bus.STB_I = 0;
    checks++; if (bus.STB_O !== 1'b0) begin errors++; $display("FAIL lat_stb1 got=%b exp=0", bus.STB_O); end
    step();
    checks++; if (bus.STB_O !== 1'b0) begin errors++; $display("FAIL lat_stb2 got=%b exp=0", bus.STB_O); end
    step();
    checks++; if (bus.STB_O !== 1'b1 || bus.DAT_O !== 32'h0000_1000) begin
      errors++; $display("FAIL lat_out got=%b/%h exp=1/00001000", bus.STB_O, bus.DAT_O); end
    drain();
    checks++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL lat_model got=%0d items exp=%0d items", got_q.size(), exp_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_complex();
    mode = 2'b10; gain_re = 16'h0000; gain_im = 16'h4000;
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1; bus.DAT_I = 32'h1000_2000;
    step();
    drain();
    checks++; if (got_q.size() != 1 || got_q[0] !== 32'h1000_F800) begin
      errors++; $display("FAIL complex got=%h exp=1000f800 n=%0d", got_q.size() ? got_q[0] : 32'h0, got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sat();
    logic [31:0] want;
`ifdef CHAN_CMUL_SAT_EN
    want = 32'h8000_0000;
`else
    want = 32'h0002_0000;
`endif
    mode = 2'b10; gain_re = 16'h7FFF; gain_im = 16'h7FFF;
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1; bus.DAT_I = 32'h8000_8000;
    step();
    drain();
    checks++; if (got_q.size() != 1 || got_q[0] !== want) begin
      errors++; $display("FAIL sat_val got=%h exp=%h n=%0d", got_q.size() ? got_q[0] : 32'h0, want, got_q.size()); end
`ifdef CHAN_CMUL_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
    bus.CYC_I = 1; step(); step();
    checks++; if (sat_flag !== m_sat) begin errors++; $display("FAIL sat_clear got=%b exp=%b", sat_flag, m_sat); end
    drain();
`endif
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] hold;
    int sent = 0, guard = 0;
    bit stalled = 0;
    mode = 2'b10; gain_re = 16'($urandom); gain_im = 16'($urandom);
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1;
    while (sent < 10 && guard < 40) begin
      guard++;
      if (sent == 5 && !stalled) begin
        stalled = 1;
        bus.ACK_I = 0;
        hold = bus.DAT_O;
        for (int k = 0; k < 4; k++) begin
          bus.DAT_I = 32'($urandom);
          step();
          checks++; if (last_ack !== 1'b0 || bus.STB_O !== 1'b1 || bus.DAT_O !== hold) begin
            errors++; $display("FAIL stall_hold ack=%b stb=%b got=%h exp=%h", last_ack, bus.STB_O, bus.DAT_O, hold); end
        end
        bus.ACK_I = 1;
      end
      bus.DAT_I = 32'($urandom);
      step();
      if (last_ack) sent++;
    end
    drain();
    checks++; if (got_q.size() != 10 || exp_q.size() != 10) begin
      errors++; $display("FAIL stall_count got=%0d exp=10 model=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_symbol();
    int base;
    logic [15:0] v, w;
    end_log.delete(); exp_end_q.delete();
    mode = 2'b01; gain_re = 16'h4000; gain_im = 16'h1234;
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1;
    base = stepno;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) gain_re = 16'h2000;
      v = 16'h0400 * 16'(i + 1);
      bus.DAT_I = {16'h0000, v};
      step();
      checks++; if (last_ack !== 1'b1) begin errors++; $display("FAIL sym_ack[%0d] got=%b exp=1", i, last_ack); end
      if (i == 1) begin
        checks++; if (sym_cnt !== 2'd2) begin errors++; $display("FAIL sym_cnt got=%0d exp=2", sym_cnt); end
      end
    end
    drain();
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      v = 16'h0400 * 16'(i + 1);
      w = (i < 4) ? (v >> 1) : (v >> 2);
      checks++; if (got_q[i] !== {16'h0000, w}) begin errors++; $display("FAIL sym_scale[%0d] got=%h exp=%h", i, got_q[i], {16'h0000, w}); end
    end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL sym_count got=%0d exp=8", got_q.size()); end
    checks++; if (end_log.size() != 2 || end_log[0] != base + 4 || end_log[1] != base + 8) begin
      errors++; $display("FAIL sym_end n=%0d first=%0d exp=%0d,%0d", end_log.size(), end_log.size() ? end_log[0] : -1, base + 4, base + 8); end
    checks++; if (sym_cnt !== 2'd0) begin errors++; $display("FAIL sym_wrap got=%0d exp=0", sym_cnt); end
    got_q.delete(); exp_q.delete(); end_log.delete(); exp_end_q.delete();
  endtask

  task automatic test_reset_inflight();
    mode = 2'b00; gain_re = 16'($urandom); gain_im = 16'($urandom);
    bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ACK_I = 1;
    for (int i = 0; i < 3; i++) begin
      bus.DAT_I = 32'h1111_0001 * 32'(i + 1);
      step();
    end
    bus.STB_I = 0;
    #1 RST_I = 1;
    #1;
    checks++; if ({bus.DAT_O, bus.STB_O, bus.CYC_O} !== '0 || sym_cnt !== '0) begin
      errors++; $display("FAIL rst_async dat=%h stb=%b cyc=%b cnt=%0d exp=0", bus.DAT_O, bus.STB_O, bus.CYC_O, sym_cnt); end
    bus.CYC_I = 0;
    @(negedge CLK_I);
    RST_I = 0;
    reset_model();
    step();
    bus.CYC_I = 1; bus.STB_I = 1; bus.DAT_I = 32'hCAFE_0001;
    step();
    bus.STB_I = 0;
    checks++; if (last_ack !== 1'b1 || sym_cnt !== 2'd1) begin
      errors++; $display("FAIL rst_new ack=%b cnt=%0d exp=1/1", last_ack, sym_cnt); end
    checks++; if (bus.STB_O !== 1'b0) begin errors++; $display("FAIL rst_stale1 got=%b exp=0", bus.STB_O); end
    step();
    checks++; if (bus.STB_O !== 1'b0) begin errors++; $display("FAIL rst_stale2 got=%b exp=0", bus.STB_O); end
    step();
    checks++; if (bus.STB_O !== 1'b1 || bus.DAT_O !== 32'hCAFE_0001) begin
      errors++; $display("FAIL rst_out got=%b/%h exp=1/cafe0001", bus.STB_O, bus.DAT_O); end
    drain();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    end_log.delete(); exp_end_q.delete();
    bus.CYC_I = 1; bus.WE_I = 1;
    for (int c = 0; c < 400; c++) begin
      bus.STB_I = ($urandom_range(0, 3) != 0);
      bus.ACK_I = ($urandom_range(0, 3) != 0);
      bus.WE_I  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.CYC_I = ~bus.CYC_I;
      else if (!bus.CYC_I) bus.CYC_I = 1;
      bus.DAT_I = 32'($urandom);
      gain_re   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      gain_im   = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      mode      = 2'($urandom);
      step();
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (end_log != exp_end_q) begin
      errors++; $display("FAIL rand_symend got=%0d pulses exp=%0d pulses", end_log.size(), exp_end_q.size()); end
    checks++; if (bus.CYC_O !== 1'b0) begin errors++; $display("FAIL rand_cyc_o got=%b exp=0", bus.CYC_O); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    RST_I = 1;
    bus.DAT_I = '0; bus.CYC_I = 0; bus.STB_I = 0; bus.WE_I = 0; bus.ACK_I = 0;
    gain_re = '0; gain_im = '0; mode = 2'b00;
    reset_model();
    test_reset();
    test_real_latency();
    test_complex();
    test_sat();
    test_stall();
    test_symbol();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/chan_cmul_sym.md
Name: chan_cmul_sym

Overview:
- Parametrised complex channel-gain multiplier for the OFDM reconfigurable PHY, placed between the modulator/IFFT chain and the channel/DAC path.
- Multiplies each streamed I/Q sample by a complex gain G = GAIN_RE_I + j·GAIN_IM_I.
- The gain is latched once per symbol, so it never changes mid-symbol.
- Successor block additions: generic sample width, programmable symbol length, bypass/real/complex modes, full back-pressure through a stallable pipeline.

Parameters:
DW, 16, I and Q component width (two's complement, Q1.(DW-1))
FRAC, 15, fractional bits of gain; product right-shift amount
SYM_LEN, 480, samples per symbol; gain reload boundary
CW, 9, symbol counter width; ceil(log2(SYM_LEN)), min 1

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset, asynchronous, active-high
DAT_I  in  2*DW  input sample {Im[2DW-1:DW], Re[DW-1:0]}
CYC_I  in  1  upstream frame cycle
STB_I  in  1  upstream strobe
WE_I  in  1  upstream write
ACK_O  out  1  sample accepted
GAIN_RE_I  in  DW  gain real part, Q1.FRAC
GAIN_IM_I  in  DW  gain imaginary part
MODE_I  in  2  00 bypass, 01 real (GAIN_IM forced 0), 1x complex
DAT_O  out  2*DW  output sample {Im, Re}
STB_O  out  1  output valid
CYC_O  out  1  downstream frame cycle
WE_O  out  1  equals STB_O
ACK_I  in  1  downstream accept
SYM_CNT_O  out  CW  index of next sample within symbol
SYM_END_O  out  1  1-cycle pulse when last sample of a symbol is accepted

Behaviour:
- Reset (async, any time): DAT_O=0, STB_O=0, CYC_O=0, SYM_CNT_O=0, SYM_END_O=0. Pipeline valid bits clear; latched gain=0, latched mode=bypass. Outstanding samples are discarded.
- Stall: halt = STB_O & ~ACK_I. While halt is high, every pipeline stage and DAT_O hold their values.
- Accept: ACK_O = CYC_I & STB_I & WE_I & ~halt (combinational). A sample is accepted on each cycle where ACK_O=1.
- Pipeline: S1 registers sample and gain; S2 registers the four DW×DW products; S3 registers summed, rounded, limited result into DAT_O with STB_O=1.
  - Latency: accept at cycle n → STB_O=1 at n+3 when there is no stall.
  - Each stall cycle adds one cycle of latency.
  - Throughput: 1 sample/cycle.
- STB_O clears when the output is taken (ACK_I=1) and no new S2 result is valid.
- Arithmetic (2DW+1-bit signed accumulate):
  - Re = aRe·gRe − aIm·gIm
  - Im = aRe·gIm + aIm·gRe
  - Round half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
  - Reduce to DW bits per Optional Feature.
- Bypass mode: DAT_O = DAT_I, with the same 3-cycle latency and identical handshake.
- Symbol counter:
  - Increments per accepted sample; at SYM_LEN-1 it wraps to 0 and SYM_END_O pulses the following cycle.
  - Rising edge of CYC_I (registered compare) forces counter to 0. If a sample is accepted on that same cycle, it counts as index 0.
- Gain/mode latch: GAIN_RE_I, GAIN_IM_I and MODE_I are sampled only on acceptance of an index-0 sample. That value applies to all SYM_LEN samples of the symbol; changes mid-symbol take effect at the next symbol.
- CYC_O:
  - Set on first accept while CYC_I=1.
  - Cleared when CYC_I=0, pipeline empty and STB_O=0.
  - CYC_I falling mid-symbol: already-accepted samples still drain; counter reset occurs at next CYC_I rise.
- Simultaneous events: accept at the same cycle as output-take is legal (no bubble). A stall arriving the same cycle as SYM_END blocks acceptance, so SYM_END does not pulse until the sample is actually accepted.

Optional Feature:
- Macro CHAN_CMUL_SAT_EN.
- Defined: after the shift, each component saturates to [−2^(DW-1), 2^(DW-1)−1]. Sticky output bit SAT_FLAG_O (1 bit) sets on any saturation and clears on reset or CYC_I rise.
- Undefined: take low DW bits (wrap); the SAT_FLAG_O port does not exist.

Test Plan:
1. DW=16, MODE=01, G=0x4000, input Re=0x2000 Im=0x0000 → DAT_O=0x0000_1000 exactly 3 cycles after ACK_O.
2. MODE=10, G=(0x0000,0x4000), input (Re 0x2000, Im 0x1000) → DAT_O Re=0xF800, Im=0x1000.
3. MODE=10, G=(0x7FFF,0x7FFF), input (0x8000,0x8000) → Re=0x0000. Im=0x8000 with CHAN_CMUL_SAT_EN (SAT_FLAG_O=1); Im=0x0002 without.
4. Stream 10 samples, hold ACK_I=0 for 4 cycles mid-stream → DAT_O/STB_O stable, ACK_O=0 during halt, all 10 outputs delivered in order, none lost or duplicated.
5. SYM_LEN=4, change G from 0x4000 to 0x2000 after 2nd sample → samples 0–3 scaled ×0.5, samples 4–7 ×0.25; SYM_END_O pulses after samples 3 and 7.
6. Assert RST_I asynchronously with 3 samples in flight → all outputs 0 immediately. After release, a new CYC_I frame starts at SYM_CNT_O=0 with no stale output.
